// File: rtl/coin_credit_ctrl_pkg.sv
// Shared types and constants for the coin/credit front end and the display path.
// Pure declarations: no logic, no latency, no flow control.
package coin_credit_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DENY = 2'd2
  } state_t;

  localparam int CREDIT_W = 7;
  localparam int TIMER_W  = 32;

  localparam int unsigned DEF_COIN_VALUE = 1;
  localparam int unsigned DEF_GAME_COST  = 3;
  localparam int unsigned DEF_MAX_CREDIT = 99;

  // Clamp an 8-bit intermediate credit value to the ceiling.
  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [7:0] v, input logic [7:0] lim);
    sat_credit = (v > lim) ? lim[CREDIT_W-1:0] : v[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/coin_credit_ctrl_btn_pulse.sv
// Button conditioner: 2-flop sync, optional debounce (COIN_CTRL_DEBOUNCE_EN), rising-edge pulse.
// Latency 3 edges (3 + DEBOUNCE_CYCLES with debounce); no backpressure, one pulse per held level.
module btn_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic lvl;
  logic lvl_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
    end
  end

`ifdef COIN_CTRL_DEBOUNCE_EN
  logic [31:0] db_cnt;
  logic        db_lvl;

  // A new level must persist for the full window before it is passed on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_cnt <= '0;
      db_lvl <= 1'b0;
    end else if (sync_2 == db_lvl) begin
      db_cnt <= '0;
    end else if (db_cnt == 32'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt <= '0;
      db_lvl <= sync_2;
    end else begin
      db_cnt <= db_cnt + 32'd1;
    end
  end

  assign lvl = db_lvl;
`else
  logic unused_db;
  assign unused_db = |DEBOUNCE_CYCLES;
  assign lvl       = sync_2;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lvl_q <= 1'b0;
      pulse <= 1'b0;
    end else begin
      lvl_q <= lvl;
      pulse <= lvl & ~lvl_q;
    end
  end

endmodule

// File: rtl/coin_credit_ctrl.sv
// Coin/credit sequencer: saturating credit, start gating, timed PLAY/DENY. Optional COIN_CTRL_DEBOUNCE_EN.
// Credit/outputs update 4 edges after a button rise; no backpressure, inputs are sampled every cycle.
module coin_credit_ctrl
  import coin_credit_ctrl_pkg::*;
#(
  parameter int unsigned COIN_VALUE      = DEF_COIN_VALUE,
  parameter int unsigned GAME_COST       = DEF_GAME_COST,
  parameter int unsigned MAX_CREDIT      = DEF_MAX_CREDIT,
  parameter int unsigned GAME_CYCLES     = 50_000_000,
  parameter int unsigned DENY_CYCLES     = 25_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                C_IN,
  input  logic                GAME_START,
  output logic [CREDIT_W-1:0] credit,
  output logic                game_active,
  output logic                deny,
  output logic                game_over,
  output logic                coin_ack
);

  logic coin_p;
  logic start_p;

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin_pulse (
    .clk   (CLK),
    .rst_n (RST),
    .btn   (C_IN),
    .pulse (coin_p)
  );

  btn_pulse #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_pulse (
    .clk   (CLK),
    .rst_n (RST),
    .btn   (GAME_START),
    .pulse (start_p)
  );

  state_t               state;
  state_t               state_nxt;
  logic [TIMER_W-1:0]   timer;
  logic [TIMER_W-1:0]   timer_nxt;
  logic                 accept;
  logic [CREDIT_W-1:0]  credit_nxt;
  logic                 active_nxt;
  logic                 deny_nxt;
  logic                 over_nxt;
  logic [7:0]           credit_wide;
  logic [7:0]           credit_sum;

  assign credit_wide = {1'b0, credit};

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      timer       <= '0;
      credit      <= '0;
      game_active <= 1'b0;
      deny        <= 1'b0;
      game_over   <= 1'b0;
      coin_ack    <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      credit      <= credit_nxt;
      game_active <= active_nxt;
      deny        <= deny_nxt;
      game_over   <= over_nxt;
      coin_ack    <= coin_p;
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start_p) begin
          // Sufficiency uses the credit held before any coin arriving this cycle.
          if (credit_wide >= 8'(GAME_COST)) begin
            accept    = 1'b1;
            state_nxt = PLAY;
            timer_nxt = TIMER_W'(GAME_CYCLES - 1);
          end else begin
            state_nxt = DENY;
            timer_nxt = TIMER_W'(DENY_CYCLES - 1);
          end
        end
      end
      PLAY, DENY: begin
        if (timer == '0) begin
          state_nxt = IDLE;
        end else begin
          timer_nxt = timer - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_comb begin
    active_nxt = (state_nxt == PLAY);
    deny_nxt   = (state_nxt == DENY);
    over_nxt   = (state == PLAY) && (timer == '0);
    // An accepted start implies credit >= GAME_COST, so the subtraction cannot underflow.
    credit_sum = credit_wide
               + (coin_p ? 8'(COIN_VALUE) : 8'd0)
               - (accept ? 8'(GAME_COST) : 8'd0);
    credit_nxt = sat_credit(credit_sum, 8'(MAX_CREDIT));
  end

endmodule
